// File: rtl/rdma_hdr_pkg.sv
// rdma_hdr_pkg: RDMA header layout, parser states and error codes shared by the TX/RX header stages.
package rdma_hdr_pkg;
  localparam int          HEADER_BEATS = 7;
  localparam logic [23:0] HDR_MARKER   = 24'hABABAB;
  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_RUNT   = 2'd1;
  localparam logic [1:0] ERR_MARKER = 2'd2;
  localparam logic [1:0] ERR_LENGTH = 2'd3;
  localparam logic [2:0] BEAT_OP_PSN = 3'd0;
  localparam logic [2:0] BEAT_QP     = 3'd1;
  localparam logic [2:0] BEAT_ADDR   = 3'd2;
  localparam logic [2:0] BEAT_FRAG   = 3'd3;
  localparam logic [2:0] BEAT_LEN    = 3'd4;
  localparam logic [2:0] BEAT_PKEY   = 3'd5;
  localparam logic [2:0] BEAT_SL     = 3'd6;
endpackage

// File: rtl/rx_sat_counter.sv
// rx_sat_counter: counter with increment enable that sticks at all ones.
module rx_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/rx_header_parser.sv
// rx_header_parser: strips the 7-beat RDMA header, publishes its fields and forwards only the payload.
module rx_header_parser import rdma_hdr_pkg::*; #(
  parameter int          C_AXIS_TDATA_WIDTH = 32,
  parameter int          C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH/8,
  parameter int          HEADER_BEATS       = rdma_hdr_pkg::HEADER_BEATS,
  parameter logic [23:0] HDR_MARKER         = rdma_hdr_pkg::HDR_MARKER,
  parameter int          CNT_WIDTH          = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          hdr_valid,
  output logic [7:0]                    rdma_opcode,
  output logic [23:0]                   rdma_psn,
  output logic [23:0]                   rdma_dest_qp,
  output logic [31:0]                   rdma_remote_addr,
  output logic [15:0]                   fragment_offset,
  output logic [31:0]                   rdma_length,
  output logic [15:0]                   rdma_partition_key,
  output logic [7:0]                    rdma_service_level,
  output logic                          rx_busy,
  output logic                          rx_done,
  output logic                          rx_error,
  output logic [1:0]                    rx_error_code,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          err_count
);
  state_e      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [31:0] pay_q, pay_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        rdy_q;
  logic [7:0]  opcode_q, sl_q;
  logic [23:0] psn_q, qp_q;
  logic [31:0] addr_q, len_q;
  logic [15:0] frag_q, pkey_q;
  logic        pass, s_acc, hdr_acc, last_hdr, marker_ok;
  logic [31:0] pay_inc;
  // rdy_q keeps s_axis_tready low while reset is asserted
  assign pass          = state_q == ST_PAYLOAD;
  assign s_axis_tready = rdy_q & (pass ? m_axis_tready : 1'b1);
  assign m_axis_tvalid = pass & s_axis_tvalid;
  assign m_axis_tdata  = pass ? s_axis_tdata : '0;
  assign m_axis_tkeep  = pass ? s_axis_tkeep : '0;
  assign m_axis_tlast  = pass & s_axis_tlast;
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  assign hdr_acc       = s_acc & (state_q == ST_HEADER);
  assign last_hdr      = beat_q == 3'(HEADER_BEATS - 1);
  assign marker_ok     = s_axis_tdata[31:8] == HDR_MARKER;
  assign pay_inc       = pay_q + 32'd1;
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pay_d       = pay_q;
    hdr_valid_d = hdr_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    case (state_q)
      ST_HEADER: if (s_acc) begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd0) hdr_valid_d = 1'b0;
        if (last_hdr) begin
          beat_d = 3'd0;
          if (!marker_ok) begin
            err_d   = 1'b1;
            code_d  = ERR_MARKER;
            state_d = s_axis_tlast ? ST_HEADER : ST_DROP;
          end else begin
            hdr_valid_d = 1'b1;
            pay_d       = '0;
            state_d     = s_axis_tlast ? ST_HEADER : ST_PAYLOAD;
            done_d      = s_axis_tlast && len_q == 32'd0;
            err_d       = s_axis_tlast && len_q != 32'd0;
            code_d      = err_d ? ERR_LENGTH : code_q;
          end
        end else if (s_axis_tlast) begin
          beat_d = 3'd0;
          err_d  = 1'b1;
          code_d = ERR_RUNT;
        end
      end
      ST_PAYLOAD: if (s_acc) begin
        pay_d = pay_inc;
        if (s_axis_tlast) begin
          state_d = ST_HEADER;
          done_d  = pay_inc == len_q;
          err_d   = pay_inc != len_q;
          code_d  = err_d ? ERR_LENGTH : code_q;
        end
      end
      ST_DROP: if (s_acc && s_axis_tlast) state_d = ST_HEADER;
      default: state_d = ST_HEADER;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q     <= ST_HEADER;
      beat_q      <= '0;
      pay_q       <= '0;
      hdr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pay_q       <= pay_d;
      hdr_valid_q <= hdr_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      rdy_q       <= 1'b1;
    end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      {psn_q, opcode_q} <= '0;
      qp_q              <= '0;
      addr_q            <= '0;
      frag_q            <= '0;
      len_q             <= '0;
      pkey_q            <= '0;
      sl_q              <= '0;
    end else if (hdr_acc) begin
      if (beat_q == BEAT_OP_PSN) {psn_q, opcode_q} <= s_axis_tdata;
      if (beat_q == BEAT_QP)     qp_q   <= s_axis_tdata[23:0];
      if (beat_q == BEAT_ADDR)   addr_q <= s_axis_tdata;
      if (beat_q == BEAT_FRAG)   frag_q <= s_axis_tdata[15:0];
      if (beat_q == BEAT_LEN)    len_q  <= s_axis_tdata;
      if (beat_q == BEAT_PKEY)   pkey_q <= s_axis_tdata[15:0];
      if (beat_q == BEAT_SL)     sl_q   <= s_axis_tdata[7:0];
    end
  rx_sat_counter #(.W(CNT_WIDTH)) u_pkt_cnt (.clk(aclk), .rst_n(aresetn), .inc_i(done_d), .cnt_o(pkt_count));
  rx_sat_counter #(.W(CNT_WIDTH)) u_err_cnt (.clk(aclk), .rst_n(aresetn), .inc_i(err_d), .cnt_o(err_count));
  assign hdr_valid          = hdr_valid_q;
  assign rdma_opcode        = opcode_q;
  assign rdma_psn           = psn_q;
  assign rdma_dest_qp       = qp_q;
  assign rdma_remote_addr   = addr_q;
  assign fragment_offset    = frag_q;
  assign rdma_length        = len_q;
  assign rdma_partition_key = pkey_q;
  assign rdma_service_level = sl_q;
  assign rx_busy            = state_q != ST_HEADER || beat_q != 3'd0;
  assign rx_done            = done_q;
  assign rx_error           = err_q;
  assign rx_error_code      = code_q;
endmodule
